// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, counter widths and the colour-bar helper
// used by the VGA timing generator and its pattern stage.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;

    localparam int unsigned CNT_W = 10;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgbPixel;

    // 64-pixel bars whose colour sequence repeats every 512 pixels.
    function automatic rgbPixel colourBar(input logic [CNT_W-1:0] hCount);
        rgbPixel px;
        px.r = hCount[8];
        px.g = hCount[7];
        px.b = hCount[6];
        return px;
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel-enable divider, horizontal/vertical counters and combinational sync and
// video-active decode from the current counter values.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_pkg::V_BACK
) (
    input  logic                      Clock,
    input  logic                      Reset,
    output logic [vga_pkg::CNT_W-1:0] hCount,
    output logic [vga_pkg::CNT_W-1:0] vCount,
    output logic                      videoActive,
    output logic                      hSyncRaw,
    output logic                      vSyncRaw
);
    import vga_pkg::*;

    localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] HLast      = CNT_W'(HTotal - 1);
    localparam logic [CNT_W-1:0] VLast      = CNT_W'(VTotal - 1);
    localparam logic [CNT_W-1:0] HVis       = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] VVis       = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HSyncFirst = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HSyncLast  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VSyncFirst = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VSyncLast  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    logic pixelEn;

    // Counters step on edges where the half-rate enable was already high.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pixelEn <= 1'b0;
            hCount  <= '0;
            vCount  <= '0;
        end else begin
            pixelEn <= ~pixelEn;
            if (pixelEn) begin
                if (hCount == HLast) begin
                    hCount <= '0;
                    if (vCount == VLast) begin
                        vCount <= '0;
                    end else begin
                        vCount <= vCount + CntOne;
                    end
                end else begin
                    hCount <= hCount + CntOne;
                end
            end
        end
    end

    always_comb begin
        videoActive = (hCount < HVis) && (vCount < VVis);
        hSyncRaw    = ~((hCount >= HSyncFirst) && (hCount <= HSyncLast));
        vSyncRaw    = ~((vCount >= VSyncFirst) && (vCount <= VSyncLast));
    end

endmodule

// File: rtl/vga_control.sv
// 640x480@60 VGA colour-bar source: timing from vga_sync_gen, with pattern
// selection and every pin driven from a register one clock behind the counters.
module vga_control #(
    parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_pkg::V_BACK
) (
    input  logic Clock,
    input  logic Reset,
    output logic oVGA_R,
    output logic oVGA_G,
    output logic oVGA_B,
    output logic oHorizontal_Sync,
    output logic oVertical_Sync
);
    import vga_pkg::*;

    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic             videoActive;
    logic             hSyncRaw;
    logic             vSyncRaw;
    rgbPixel          barColour;
    logic             unusedVCount;

    vga_sync_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) syncGen (
        .Clock       (Clock),
        .Reset       (Reset),
        .hCount      (hCount),
        .vCount      (vCount),
        .videoActive (videoActive),
        .hSyncRaw    (hSyncRaw),
        .vSyncRaw    (vSyncRaw)
    );

    // The bar pattern depends only on the horizontal position.
    assign unusedVCount = ^vCount;

    always_comb begin
        barColour = '0;
        if (videoActive) begin
            barColour = colourBar(hCount);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oVGA_R           <= 1'b0;
            oVGA_G           <= 1'b0;
            oVGA_B           <= 1'b0;
            oHorizontal_Sync <= 1'b1;
            oVertical_Sync   <= 1'b1;
        end else begin
            oVGA_R           <= barColour.r;
            oVGA_G           <= barColour.g;
            oVGA_B           <= barColour.b;
            oHorizontal_Sync <= hSyncRaw;
            oVertical_Sync   <= vSyncRaw;
        end
    end

endmodule

// File: tb/tb_vga_control.sv
// Scoreboard bench for vga_control: full horizontal timing, shortened vertical
// timing so that two complete frames fit in a short run.
module tb_vga_control;

    localparam int unsigned HTot   = 800;
    localparam int unsigned VVis   = 8;
    localparam int unsigned VFront = 2;
    localparam int unsigned VSyncW = 2;
    localparam int unsigned VBack  = 3;
    localparam int unsigned VTot   = VVis + VFront + VSyncW + VBack;
    localparam int unsigned LineClk  = 2 * HTot;
    localparam int unsigned FrameClk = LineClk * VTot;
    localparam logic [4:0]  RstOut = 5'b00011;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic oVGA_R, oVGA_G, oVGA_B, oHorizontal_Sync, oVertical_Sync;

    vga_control #(
        .V_VISIBLE (VVis),
        .V_FRONT   (VFront),
        .V_SYNC    (VSyncW),
        .V_BACK    (VBack)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .oVGA_R           (oVGA_R),
        .oVGA_G           (oVGA_G),
        .oVGA_B           (oVGA_B),
        .oHorizontal_Sync (oHorizontal_Sync),
        .oVertical_Sync   (oVertical_Sync)
    );

    always #10 Clock = ~Clock;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned edgeCnt  = 0;
    logic [4:0]  sb[$];
    logic [4:0]  lastExp;
    logic        prevH, prevV;
    int unsigned hFall[2];
    int unsigned hRise;
    int unsigned vFall[2];
    int unsigned vRise;
    int unsigned nHFall, nVFall;

    // Bar probes: (line, hcount) -> expected RGB
    int unsigned probeLine[11] = '{0, 0,  0,   0,   0,   0,   0,   0,   0,   5,    VVis};
    int unsigned probeH[11]    = '{0, 63, 64,  127, 448, 511, 512, 575, 639, 640,  64};
    logic [2:0]  probeRgb[11]  = '{0, 0,  1,   1,   7,   7,   0,   0,   1,   0,    0};

    function automatic logic [4:0] dutOut();
        return {oVGA_R, oVGA_G, oVGA_B, oHorizontal_Sync, oVertical_Sync};
    endfunction

    // Output after release edge k reflects the counters after edge k-1.
    function automatic logic [4:0] expOut(input int unsigned k);
        int unsigned tick, hc, vc;
        logic act, hs, vs;
        logic [2:0] rgb;
        tick = (k - 1) / 2;
        hc   = tick % HTot;
        vc   = (tick / HTot) % VTot;
        act  = (hc < 640) && (vc < VVis);
        hs   = !((hc >= 656) && (hc <= 751));
        vs   = !((vc >= VVis + VFront) && (vc <= VVis + VFront + VSyncW - 1));
        rgb  = act ? {hc[8], hc[7], hc[6]} : 3'b000;
        return {rgb, hs, vs};
    endfunction

    function automatic int unsigned edgeFor(input int unsigned line, input int unsigned hc);
        return 2 * (line * HTot + hc) + 1;
    endfunction

    task automatic checkVal(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic stepClock();
        logic [4:0] got, exp;
        @(posedge Clock);
        edgeCnt++;
        lastExp = expOut(edgeCnt);
        sb.push_back(lastExp);
        #1;
        got = dutOut();
        exp = sb.pop_front();
        checkVal($sformatf("pix@%0d", edgeCnt), got, exp);
        for (int i = 0; i < 11; i++) begin
            if (edgeCnt == edgeFor(probeLine[i], probeH[i])) begin
                checkVal($sformatf("bar L%0d h%0d", probeLine[i], probeH[i]),
                         got[4:2], probeRgb[i]);
            end
        end
        if (edgeCnt == edgeFor(VTot, 0)) checkVal("wrap00", got, RstOut);
        if (prevH && !got[1]) begin
            if (nHFall < 2) hFall[nHFall] = edgeCnt;
            nHFall++;
        end
        if (!prevH && got[1] && nHFall == 1) hRise = edgeCnt;
        if (prevV && !got[0]) begin
            if (nVFall < 2) vFall[nVFall] = edgeCnt;
            nVFall++;
        end
        if (!prevV && got[0] && nVFall == 1) vRise = edgeCnt;
        prevH = got[1];
        prevV = got[0];
    endtask

    initial begin
        prevH = 1'b1; prevV = 1'b1;
        nHFall = 0; nVFall = 0;
        hFall = '{0, 0}; vFall = '{0, 0}; hRise = 0; vRise = 0;
        lastExp = RstOut;

        repeat (10) begin
            @(posedge Clock);
            #1 checkVal("rstHold", dutOut(), RstOut);
        end
        @(negedge Clock);
        Reset = 1'b0;

        repeat (2 * FrameClk + 400) stepClock();

        checkVal("hFallFirst", hFall[0], 1313);
        checkVal("hLowWidth", hRise - hFall[0], 192);
        checkVal("hPeriod", hFall[1] - hFall[0], LineClk);
        checkVal("vFallFirst", vFall[0], (VVis + VFront) * LineClk + 1);
        checkVal("vLowWidth", vRise - vFall[0], VSyncW * LineClk);
        checkVal("vPeriod", vFall[1] - vFall[0], FrameClk);

        // Park on a non-reset output value, then reset between edges.
        for (int i = 0; i < 2000 && lastExp == RstOut; i++) stepClock();
        @(posedge Clock);
        #3 Reset = 1'b1;
        #1 checkVal("asyncRst", dutOut(), RstOut);
        repeat (3) begin
            @(posedge Clock);
            #1 checkVal("rstHold2", dutOut(), RstOut);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
